// File: rtl/axi_burst_read_master.sv
// AXI4 INCR read master: splits a request into <=MAX_BURST, 4 KB-safe bursts, one outstanding; R data passes to out_* with zero latency.
// Backpressure: RREADY follows out_ready in DATA. Optional watchdog under AXI_RD_TIMEOUT_EN.
module axi_burst_read_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int MAX_BURST      = 16,
  parameter int REQ_LEN_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_read,
  input  logic [ADDR_WIDTH-1:0]    target_read_addr,
  input  logic [REQ_LEN_WIDTH-1:0] target_read_beats,
  output logic                     busy,
  output logic                     done_read,
  output logic                     read_err,
  output logic                     read_timeout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic [ADDR_WIDTH-1:0]    ARADDR,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  output logic [LEN_WIDTH-1:0]     ARLEN,
  output logic [2:0]               ARSIZE,
  output logic [1:0]               ARBURST,
  input  logic [DATA_WIDTH-1:0]    RDATA,
  input  logic                     RVALID,
  output logic                     RREADY,
  input  logic                     RLAST,
  input  logic [1:0]               RRESP
);

  localparam int LG = $clog2(DATA_WIDTH / 8);
  localparam int CW0 = (REQ_LEN_WIDTH > 13) ? REQ_LEN_WIDTH : 13;
  localparam int CW = (CW0 > LEN_WIDTH + 1) ? CW0 : LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << LG) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic [REQ_LEN_WIDTH-1:0] remaining;
  logic [CW-1:0]            burst_size;
  logic [CW-1:0]            burst_cnt;
  logic [CW-1:0]            size_c;
  logic [CW-1:0]            bnd_c;
  logic [CW-1:0]            rem_c;
  logic                     in_data;
  logic                     accept;
  logic                     ar_hs;
  logic                     r_hs;
  logic                     burst_end;
  logic                     last_beat;
  logic                     to_hit;
  logic                     unused_ok;

  assign ARSIZE  = 3'(LG);
  assign ARBURST = 2'b01;

  assign in_data   = (state == S_DATA);
  assign out_valid = in_data && RVALID;
  assign RREADY    = in_data && out_ready;
  assign out_data  = in_data ? RDATA : '0;
  assign last_beat = (remaining == REQ_LEN_WIDTH'(1));
  assign out_last  = out_valid && last_beat;

  assign accept    = (state == S_IDLE) && start_read;
  assign ar_hs     = ARVALID && ARREADY;
  assign r_hs      = RVALID && RREADY;
  assign burst_end = r_hs && (burst_cnt == burst_size - CW'(1));

  assign unused_ok = ^{RRESP[0], TIMEOUT_CYCLES[0]};

  // Beats left before the next 4 KB page, limited by request and MAX_BURST.
  always_comb begin
    rem_c  = CW'(remaining);
    bnd_c  = CW'((13'd4096 - {1'b0, cur_addr[11:0]}) >> LG);
    size_c = rem_c;
    if (CW'(MAX_BURST) < size_c) size_c = CW'(MAX_BURST);
    if (bnd_c < size_c) size_c = bnd_c;
  end

`ifdef AXI_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_run;

  assign to_run = ((state == S_ADDR) || (state == S_DATA)) && !(ar_hs || r_hs);
  assign to_hit = to_run && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt       <= '0;
      read_timeout <= 1'b0;
    end else begin
      to_cnt <= to_run ? to_cnt + TW'(1) : '0;
      if (accept) read_timeout <= 1'b0;
      else if (to_hit) read_timeout <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign read_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done_read  <= 1'b0;
      read_err   <= 1'b0;
      ARVALID    <= 1'b0;
      ARADDR     <= '0;
      ARLEN      <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      burst_size <= '0;
      burst_cnt  <= '0;
    end else begin
      done_read <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_read) begin
            cur_addr  <= target_read_addr & ALIGN_MASK;
            remaining <= target_read_beats;
            read_err  <= 1'b0;
            busy      <= 1'b1;
            state     <= (target_read_beats == '0) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: begin
          if (to_hit) begin
            ARVALID  <= 1'b0;
            read_err <= 1'b1;
            state    <= S_DONE;
          end else if (!ARVALID) begin
            ARADDR     <= cur_addr;
            ARLEN      <= LEN_WIDTH'(size_c - CW'(1));
            burst_size <= size_c;
            burst_cnt  <= '0;
            ARVALID    <= 1'b1;
          end else if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (to_hit) begin
            read_err <= 1'b1;
            state    <= S_DONE;
          end else if (r_hs) begin
            remaining <= remaining - REQ_LEN_WIDTH'(1);
            burst_cnt <= burst_cnt + CW'(1);
            if (RRESP[1]) read_err <= 1'b1;
            // The beat count, not RLAST, ends the burst; RLAST is only cross-checked.
            if (burst_end) begin
              if (!RLAST) read_err <= 1'b1;
              cur_addr <= cur_addr + (ADDR_WIDTH'(burst_size) << LG);
              state    <= last_beat ? S_DONE : S_ADDR;
            end else if (RLAST) begin
              read_err <= 1'b1;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          done_read <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Scoreboard bench: expected AR commands, data beats and error flags are queued at issue time
// and checked by an independent monitor; a behavioural AXI slave returns addr^KEY as data.
module tb_axi_burst_read_master;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_read;
  logic [31:0] target_read_addr;
  logic [15:0] target_read_beats;
  logic        busy, done_read, read_err, read_timeout;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [31:0] RDATA;
  logic        RVALID, RREADY, RLAST;
  logic [1:0]  RRESP;

  axi_burst_read_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .MAX_BURST(16),
    .REQ_LEN_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start_read(start_read),
    .target_read_addr(target_read_addr), .target_read_beats(target_read_beats),
    .busy(busy), .done_read(done_read), .read_err(read_err), .read_timeout(read_timeout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  logic [39:0] exp_ar[$];
  beat_t       exp_beat[$];
  logic        exp_err[$];
  logic ar_rdy_en = 1'b1;
  logic tog = 1'b0;
  int   err_beat = -1;
  int   g_beat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: handshakes seen at the negedge complete on the next posedge.
  initial begin : monitor
    logic [39:0] e;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) chk("unexpected_ar", ARADDR, 32'hFFFF_FFFF);
          else begin
            e = exp_ar.pop_front();
            chk("araddr", ARADDR, e[39:8]);
            chk("arlen", 32'(ARLEN), 32'(e[7:0]));
            chk("arsize", 32'(ARSIZE), 32'd2);
            chk("arburst", 32'(ARBURST), 32'd1);
          end
        end
        if (out_valid && out_ready) begin
          beat_cnt++;
          if (exp_beat.size() == 0) chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
          else begin
            b = exp_beat.pop_front();
            chk("out_data", out_data, b.d);
            chk("out_last", 32'(out_last), 32'(b.l));
          end
        end
        if (done_read) begin
          done_cnt++;
          chk("done_busy", 32'(busy), 32'd0);
          if (exp_err.size() == 0) chk("unexpected_done", 32'(done_read), 32'd0);
          else chk("read_err", 32'(read_err), 32'(exp_err.pop_front()));
        end
      end
    end
  end

  // Behavioural AXI read slave plus out_ready pattern generator.
  initial begin : slave
    logic ar_h, r_h, st;
    logic [31:0] cap_addr, s_addr;
    logic [7:0] cap_len;
    int s_left;
    logic s_act;
    s_act = 1'b0; s_left = 0; s_addr = '0;
    ARREADY = 1'b1; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      ar_h = ARVALID && ARREADY;
      r_h = RVALID && RREADY;
      st = start_read && !busy;
      cap_addr = ARADDR;
      cap_len = ARLEN;
      @(posedge clk);
      #1;
      if (rst) begin
        s_act = 1'b0; s_left = 0;
      end else begin
        if (st) g_beat = 0;
        if (r_h) begin
          s_addr = s_addr + 32'd4; s_left--; g_beat++;
          if (s_left == 0) s_act = 1'b0;
        end
        if (ar_h) begin
          s_act = 1'b1; s_addr = cap_addr; s_left = int'(cap_len) + 1;
        end
      end
      RVALID = s_act;
      RDATA = s_addr ^ KEY;
      RLAST = (s_left == 1);
      RRESP = (s_act && g_beat == err_beat) ? 2'b10 : 2'b00;
      ARREADY = ar_rdy_en;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  task automatic push_beats(input logic [31:0] a, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = (a + 32'(4 * i)) ^ KEY;
      b.l = (i == n - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic issue(input logic [31:0] a, input int n);
    target_read_addr = a;
    target_read_beats = 16'(n);
    start_read = 1'b1;
    @(posedge clk);
    #1;
    start_read = 1'b0;
  endtask

  task automatic run_req(input string nm, input logic [31:0] a, input int n, input logic err);
    int prev;
    prev = done_cnt;
    exp_err.push_back(err);
    push_beats(a, n);
    issue(a, n);
    for (int c = 0; c < 2000 && done_cnt == prev; c++) @(posedge clk);
    #1;
    chk({nm, "_done_seen"}, 32'(done_cnt), 32'(prev + 1));
    chk({nm, "_ar_left"}, 32'(exp_ar.size()), 32'd0);
    chk({nm, "_beats_left"}, 32'(exp_beat.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int prev, pb, n;
    start_read = 1'b0;
    target_read_addr = '0;
    target_read_beats = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_read), 32'd0);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_rready", 32'(RREADY), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_read_err", 32'(read_err), 32'd0);
    chk("rst_read_timeout", 32'(read_timeout), 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_arlen", 32'(ARLEN), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_ar.push_back({32'h100, 8'd3});
    run_req("t1", 32'h100, 4, 1'b0);
    chk("t1_read_timeout", 32'(read_timeout), 32'd0);

    exp_ar.push_back({32'h000, 8'd15});
    exp_ar.push_back({32'h040, 8'd15});
    exp_ar.push_back({32'h080, 8'd7});
    run_req("t2", 32'h000, 40, 1'b0);

    exp_ar.push_back({32'hFF8, 8'd1});
    exp_ar.push_back({32'h1000, 8'd3});
    run_req("t3", 32'hFF8, 6, 1'b0);

    tog = 1'b1;
    err_beat = 2;
    exp_ar.push_back({32'h300, 8'd7});
    run_req("t4", 32'h300, 8, 1'b1);
    tog = 1'b0;
    err_beat = -1;
    repeat (2) @(posedge clk);
    #1;

    exp_ar.push_back({32'h400, 8'd7});
    push_beats(32'h400, 8);
    pb = beat_cnt;
    issue(32'h400, 8);
    chk("t5_busy_on_accept", 32'(busy), 32'd1);
    chk("t5_err_cleared", 32'(read_err), 32'd0);
    for (int c = 0; c < 200 && beat_cnt < pb + 3; c++) @(posedge clk);
    chk("t5_beats_before_rst", 32'(beat_cnt >= pb + 3), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_arvalid", 32'(ARVALID), 32'd0);
    chk("t5_rst_rready", 32'(RREADY), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    exp_ar.delete();
    exp_beat.delete();
    exp_err.delete();
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_ar.push_back({32'h200, 8'd1});
    run_req("t5b", 32'h200, 2, 1'b0);

    prev = done_cnt;
    exp_err.push_back(1'b0);
    issue(32'h0, 0);
    chk("t5c_done_c1", 32'(done_read), 32'd0);
    chk("t5c_busy_c1", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("t5c_done_c2", 32'(done_read), 32'd1);
    chk("t5c_busy_c2", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("t5c_done_c3", 32'(done_read), 32'd0);
    chk("t5c_done_count", 32'(done_cnt), 32'(prev + 1));

`ifdef AXI_RD_TIMEOUT_EN
    ar_rdy_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_err.push_back(1'b1);
    issue(32'h500, 4);
    for (int c = 0; c < 50 && !ARVALID; c++) begin
      @(posedge clk);
      #1;
    end
    n = 0;
    while (!done_read && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_done_delay", 32'(n), 32'd16);
    chk("t6_arvalid", 32'(ARVALID), 32'd0);
    chk("t6_read_timeout", 32'(read_timeout), 32'd1);
    chk("t6_read_err", 32'(read_err), 32'd1);
    ar_rdy_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
